// File: rtl/wbs_ctrl.sv
`default_nettype none
// ============================================================================
// wbs_ctrl : Wishbone debug slave for the ANN accelerator (regs, SRAMs, tree).
// Option   : WBS_DEBUG_GATE_EN blocks memory regions while wbs_debug=0.
// Revision : 1.0
// ============================================================================
module wbs_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int LEAF_SIZE  = 8,
  parameter int PATCH_SIZE = 5,
  parameter int ROW_SIZE   = 24,
  parameter int COL_SIZE   = 17,
  parameter int K          = 4,
  parameter int NUM_LEAVES = 64,
  localparam int PW         = PATCH_SIZE * DATA_WIDTH,
  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  localparam int QADDRW     = $clog2(NUM_QUERYS),
  localparam int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_dat_i,
  input  logic [31:0]                 wbs_adr_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  output logic                        wbs_mode,
  output logic                        wbs_debug,
  output logic                        wbs_qp_mem_csb0,
  output logic                        wbs_qp_mem_web0,
  output logic [QADDRW-1:0]           wbs_qp_mem_addr0,
  output logic [PW-1:0]               wbs_qp_mem_wpatch0,
  input  logic [PW-1:0]               wbs_qp_mem_rpatch0,
  output logic [LEAF_SIZE-1:0]        wbs_leaf_mem_csb0,
  output logic [LEAF_SIZE-1:0]        wbs_leaf_mem_web0,
  output logic [LEAF_ADDRW-1:0]       wbs_leaf_mem_addr0,
  output logic [63:0]                 wbs_leaf_mem_wleaf0,
  input  logic [LEAF_SIZE-1:0][63:0]  wbs_leaf_mem_rleaf0,
  output logic                        wbs_node_mem_web,
  output logic [31:0]                 wbs_node_mem_addr,
  output logic [31:0]                 wbs_node_mem_wdata,
  input  logic [31:0]                 wbs_node_mem_rdata
);

  localparam int BANKW = $clog2(LEAF_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] rdat_q, rdat_d;
  logic        we_q, we_d;
  logic        mode_q, mode_d;
  logic        debug_q, debug_d;

  logic                 is_reg, is_qp, is_leaf, is_node, mem_ok;
  logic [BANKW-1:0]     bank;
  logic [LEAF_SIZE-1:0] leaf_sel;
  logic [63:0]          leaf_word;
  logic [31:0]          rd_word;

  assign is_reg   = (adr_q[31:24] == 8'h30);
  assign is_qp    = (adr_q[31:24] == 8'h31);
  assign is_leaf  = (adr_q[31:24] == 8'h32);
  assign is_node  = (adr_q[31:24] == 8'h34);
  assign bank     = adr_q[BANKW:1];
  assign leaf_sel = LEAF_SIZE'(1) << bank;
  assign leaf_word = wbs_leaf_mem_rleaf0[bank];

`ifdef WBS_DEBUG_GATE_EN
  assign mem_ok = debug_q;
`else
  assign mem_ok = 1'b1;
`endif

  // Memory address/data buses follow the registered request; strobes qualify them.
  assign wbs_qp_mem_addr0    = adr_q[QADDRW:1];
  assign wbs_qp_mem_wpatch0  = {dat_q[PW-33:0], hold_q};
  assign wbs_leaf_mem_addr0  = adr_q[BANKW+LEAF_ADDRW:BANKW+1];
  assign wbs_leaf_mem_wleaf0 = {dat_q, hold_q};
  assign wbs_node_mem_addr   = adr_q;
  assign wbs_node_mem_wdata  = dat_q;

  assign wbs_ack_o = (state_q == ACK);
  assign wbs_dat_o = rdat_q;
  assign wbs_mode  = mode_q;
  assign wbs_debug = debug_q;

  always_comb begin
    rd_word = '0;
    if (is_reg) begin
      if (adr_q[23:0] == 24'd0)      rd_word = {31'b0, mode_q};
      else if (adr_q[23:0] == 24'd1) rd_word = {31'b0, debug_q};
    end else if (mem_ok) begin
      if (is_qp)
        rd_word = adr_q[0] ? {{(64-PW){1'b0}}, wbs_qp_mem_rpatch0[PW-1:32]}
                           : wbs_qp_mem_rpatch0[31:0];
      else if (is_leaf)
        rd_word = adr_q[0] ? leaf_word[63:32] : leaf_word[31:0];
      else if (is_node)
        rd_word = wbs_node_mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    hold_d  = hold_q;
    rdat_d  = rdat_q;
    mode_d  = mode_q;
    debug_d = debug_q;
    wbs_qp_mem_csb0   = 1'b1;
    wbs_qp_mem_web0   = 1'b1;
    wbs_leaf_mem_csb0 = '1;
    wbs_leaf_mem_web0 = '1;
    wbs_node_mem_web  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d   = wbs_adr_i;
          dat_d   = wbs_dat_i;
          we_d    = wbs_we_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = ACK;
          rdat_d  = '0;
          if (is_reg && adr_q[23:0] == 24'd0) mode_d  = dat_q[0];
          if (is_reg && adr_q[23:0] == 24'd1) debug_d = dat_q[0];
          if (mem_ok) begin
            // Lower halves only park in the holding register; the upper half commits the word.
            if ((is_qp || is_leaf) && !adr_q[0]) hold_d = dat_q;
            if (is_qp && adr_q[0]) begin
              wbs_qp_mem_csb0 = 1'b0;
              wbs_qp_mem_web0 = 1'b0;
            end
            if (is_leaf && adr_q[0]) begin
              wbs_leaf_mem_csb0 = ~leaf_sel;
              wbs_leaf_mem_web0 = ~leaf_sel;
            end
            if (is_node) wbs_node_mem_web = 1'b1;
          end
        end else begin
          state_d = WAIT;
          if (mem_ok && is_qp)   wbs_qp_mem_csb0   = 1'b0;
          if (mem_ok && is_leaf) wbs_leaf_mem_csb0 = ~leaf_sel;
        end
      end
      WAIT: begin
        rdat_d  = rd_word;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      hold_q  <= '0;
      rdat_q  <= '0;
      mode_q  <= 1'b0;
      debug_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      rdat_q  <= rdat_d;
      mode_q  <= mode_d;
      debug_q <= debug_d;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_sel_i, (K != 0)};

endmodule
`default_nettype wire

// File: tb/tb_wbs_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wbs_ctrl : directed + randomized bus traffic against an array-level model.
// Revision    : 1.0
// ============================================================================
module tb_wbs_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc = 1'b0, stb = 1'b0, we_i = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_i = '0, adr_i = '0;
  logic        ack, mode, debug;
  logic [31:0] dat_o;
  logic        qp_csb, qp_web;
  logic [8:0]  qp_addr;
  logic [54:0] qp_w, qp_r;
  logic [7:0]  lf_csb, lf_web;
  logic [5:0]  lf_addr;
  logic [63:0] lf_w;
  logic [7:0][63:0] lf_r;
  logic        nd_web;
  logic [31:0] nd_addr, nd_wdata, nd_rdata;

  wbs_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we_i), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .wbs_mode(mode), .wbs_debug(debug),
    .wbs_qp_mem_csb0(qp_csb), .wbs_qp_mem_web0(qp_web), .wbs_qp_mem_addr0(qp_addr),
    .wbs_qp_mem_wpatch0(qp_w), .wbs_qp_mem_rpatch0(qp_r),
    .wbs_leaf_mem_csb0(lf_csb), .wbs_leaf_mem_web0(lf_web), .wbs_leaf_mem_addr0(lf_addr),
    .wbs_leaf_mem_wleaf0(lf_w), .wbs_leaf_mem_rleaf0(lf_r),
    .wbs_node_mem_web(nd_web), .wbs_node_mem_addr(nd_addr),
    .wbs_node_mem_wdata(nd_wdata), .wbs_node_mem_rdata(nd_rdata)
  );

  // SRAM / tree stand-ins driven purely by the DUT strobes, plus strobe monitors
  logic [54:0] qp_mem [512];
  logic [63:0] lf_mem [8][64];
  logic [31:0] nd_mem [256];
  int qp_cnt = 0, lf_cnt = 0, nd_cnt = 0;
  logic [8:0]  qp_last_addr;
  logic        qp_last_web;
  logic [54:0] qp_last_w;
  logic [7:0]  lf_last_csb, lf_last_web;
  logic [63:0] lf_last_w;
  logic [31:0] nd_last_addr;

  always @(posedge clk) begin
    if (!qp_csb) begin
      qp_cnt       <= qp_cnt + 1;
      qp_last_addr <= qp_addr;
      qp_last_web  <= qp_web;
      qp_last_w    <= qp_w;
      if (!qp_web) qp_mem[qp_addr] <= qp_w;
      else         qp_r <= qp_mem[qp_addr];
    end
    if (lf_csb != 8'hFF) begin
      lf_cnt      <= lf_cnt + 1;
      lf_last_csb <= lf_csb;
      lf_last_web <= lf_web;
      lf_last_w   <= lf_w;
      for (int b = 0; b < 8; b++)
        if (!lf_csb[b]) begin
          if (!lf_web[b]) lf_mem[b][lf_addr] <= lf_w;
          else            lf_r[b] <= lf_mem[b][lf_addr];
        end
    end
    if (nd_web) begin
      nd_cnt       <= nd_cnt + 1;
      nd_last_addr <= nd_addr;
      nd_mem[nd_addr[7:0]] <= nd_wdata;
    end
  end
  assign nd_rdata = nd_mem[nd_addr[7:0]];

  // Reference model: the contents the host should see, built from bus operations only
  logic [54:0] qp_m [512];
  logic [63:0] lf_m [8][64];
  logic [31:0] nd_m [256];
  logic [31:0] hold_m = '0;
  logic        mode_m = 1'b0, debug_m = 1'b0;

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    input bit keep, output logic [31:0] rd);
    int n;
    @(negedge clk);
    chk("ack_low_in_idle", {63'b0, ack}, 64'd0);
    cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    chk("ack_seen", {63'b0, ack}, 64'd1);
    chk("ack_latency", 64'(n), we ? 64'd2 : 64'd3);
    rd = dat_o;
    if (!keep) begin
      cyc = 1'b0; stb = 1'b0;
    end
  endtask

  task automatic op(input logic we, input logic [31:0] adr, input logic [31:0] dat, input bit keep);
    logic [31:0] rd, exp;
    int q0, l0, n0, eq, el, en;
    int idx, bnk, la;
    exp = '0; eq = 0; el = 0; en = 0;
    idx = int'(adr[9:1]); bnk = int'(adr[3:1]); la = int'(adr[9:4]);
    q0 = qp_cnt; l0 = lf_cnt; n0 = nd_cnt;
    case (adr[31:24])
      8'h30: begin
        if (adr[23:0] == 24'd0) begin
          if (we) mode_m = dat[0];
          exp = {31'b0, mode_m};
        end else if (adr[23:0] == 24'd1) begin
          if (we) debug_m = dat[0];
          exp = {31'b0, debug_m};
        end
      end
      8'h31: begin
        if (we && !adr[0]) hold_m = dat;
        else if (we) qp_m[idx] = {dat[22:0], hold_m};
        if (!we || adr[0]) eq = 1;
        exp = adr[0] ? {9'b0, qp_m[idx][54:32]} : qp_m[idx][31:0];
      end
      8'h32: begin
        if (we && !adr[0]) hold_m = dat;
        else if (we) lf_m[bnk][la] = {dat, hold_m};
        if (!we || adr[0]) el = 1;
        exp = adr[0] ? lf_m[bnk][la][63:32] : lf_m[bnk][la][31:0];
      end
      8'h34: begin
        if (we) begin
          nd_m[adr[7:0]] = dat;
          en = 1;
        end
        exp = nd_m[adr[7:0]];
      end
      default: exp = '0;
    endcase
    wb(we, adr, dat, keep, rd);
    if (!we) chk("read_data", {32'b0, rd}, {32'b0, exp});
    chk("qp_strobes",   64'(qp_cnt - q0), 64'(eq));
    chk("leaf_strobes", 64'(lf_cnt - l0), 64'(el));
    chk("node_strobes", 64'(nd_cnt - n0), 64'(en));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_strobes"}, {45'b0, qp_csb, qp_web, lf_csb, lf_web, nd_web}, {45'b0, 2'b11, 8'hFF, 8'hFF, 1'b0});
    chk({tag, "_ack_dat"}, {29'b0, ack, mode, debug, dat_o}, 64'd0);
    chk({tag, "_addr"}, {17'b0, qp_addr, lf_addr, nd_addr}, 64'd0);
    chk({tag, "_wdata"}, {9'b0, qp_w}, 64'd0);
    chk({tag, "_wleaf"}, lf_w, 64'd0);
    chk({tag, "_nwdata"}, {32'b0, nd_wdata}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, adr;
    bit seen;
    int l0, q0, r;

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Control registers
    op(1'b1, 32'h3000_0001, 32'h1, 1'b0);
    chk("debug_set", {63'b0, debug}, 64'd1);
    op(1'b1, 32'h3000_0000, 32'h1, 1'b0);
    chk("mode_set", {63'b0, mode}, 64'd1);
    op(1'b0, 32'h3000_0000, 32'h0, 1'b0);
    op(1'b0, 32'h3000_0005, 32'h0, 1'b0);

    // Fill the portions of the memories that random traffic will use
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 32'h3100_0000 | 32'(i << 1), $urandom, 1'b0);
      op(1'b1, 32'h3100_0001 | 32'(i << 1), $urandom, 1'b1);
      op(1'b1, 32'h3400_0000 | 32'(i), $urandom, 1'b0);
    end
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 8; a++) begin
        op(1'b1, 32'h3200_0000 | 32'(a << 4) | 32'(b << 1), $urandom, 1'b1);
        op(1'b1, 32'h3200_0001 | 32'(a << 4) | 32'(b << 1), $urandom, 1'b0);
      end

    // qp read halves
    op(1'b1, 32'h3100_0002, 32'hDEAD_BEEF, 1'b0);
    op(1'b1, 32'h3100_0003, 32'h0000_1010, 1'b0);
    op(1'b0, 32'h3100_0002, 32'h0, 1'b0);
    chk("qp_rd_addr_web", {54'b0, qp_last_web, qp_last_addr}, {54'b0, 1'b1, 9'd1});
    wb(1'b0, 32'h3100_0002, 32'h0, 1'b0, rd);
    chk("qp_rd_lo", {32'b0, rd}, 64'h0000_0000_DEAD_BEEF);
    wb(1'b0, 32'h3100_0003, 32'h0, 1'b0, rd);
    chk("qp_rd_hi", {32'b0, rd}, 64'h0000_0000_0000_1010);

    // qp write pair -> one strobe
    q0 = qp_cnt;
    op(1'b1, 32'h3100_0004, 32'h0123_4567, 1'b0);
    op(1'b1, 32'h3100_0005, 32'h000B_CDEF, 1'b0);
    chk("qp_wr_count", 64'(qp_cnt - q0), 64'd1);
    chk("qp_wr_addr_web", {54'b0, qp_last_web, qp_last_addr}, {54'b0, 1'b0, 9'd2});
    chk("qp_wr_patch", {9'b0, qp_last_w}, {9'b0, 55'h0B_CDEF_0123_4567});

    // leaf read, bank 7
    op(1'b1, 32'h3200_000E, 32'hDEAD_BEEF, 1'b0);
    op(1'b1, 32'h3200_000F, 32'h1100_1010, 1'b0);
    wb(1'b0, 32'h3200_000E, 32'h0, 1'b0, rd);
    chk("leaf_rd_csb", {56'b0, lf_last_csb}, 64'h7F);
    chk("leaf_rd_lo", {32'b0, rd}, 64'h0000_0000_DEAD_BEEF);
    wb(1'b0, 32'h3200_000F, 32'h0, 1'b0, rd);
    chk("leaf_rd_hi", {32'b0, rd}, 64'h0000_0000_1100_1010);

    // leaf write, bank 3
    op(1'b1, 32'h3200_0006, 32'h7654_3210, 1'b0);
    op(1'b1, 32'h3200_0007, 32'hFEDC_BA98, 1'b0);
    chk("leaf_wr_csb_web", {48'b0, lf_last_csb, lf_last_web}, 64'hF7F7);
    chk("leaf_wr_data", lf_last_w, 64'hFEDC_BA98_7654_3210);

    // node pass-through
    op(1'b1, 32'h3400_0001, 32'hCAFE_F00D, 1'b0);
    chk("node_wr_addr", {32'b0, nd_last_addr}, 64'h3400_0001);
    op(1'b0, 32'h3400_0001, 32'h0, 1'b0);

    // reserved region
    op(1'b1, 32'h3300_0001, 32'h1234_5678, 1'b0);
    op(1'b0, 32'h3300_0001, 32'h0, 1'b0);

    // reset during a node read
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h3400_0003; dat_i = '0;
    @(negedge clk);
    seen = ack;
    @(negedge clk);
    seen = seen | ack;
    rst = 1'b1;
    @(negedge clk);
    seen = seen | ack;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rst_read_no_ack", {63'b0, seen}, 64'd0);
    chk_reset_state("rst_read");
    rst = 1'b0;
    hold_m = '0; mode_m = 1'b0; debug_m = 1'b0;

    // reset during an upper-half leaf write: memory must stay untouched
    op(1'b1, 32'h3200_0010, 32'hAAAA_AAAA, 1'b0);
    l0 = lf_cnt;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = 32'h3200_0011; dat_i = 32'h5555_5555;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rst_write_no_strobe", 64'(lf_cnt - l0), 64'd0);
    rst = 1'b0;
    hold_m = '0; mode_m = 1'b0; debug_m = 1'b0;
    op(1'b0, 32'h3200_0011, 32'h0, 1'b0);
    op(1'b0, 32'h3000_0001, 32'h0, 1'b0);

    // holding register restarts at zero after reset
    op(1'b1, 32'h3100_0007, 32'h0012_3456, 1'b0);
    chk("hold_after_reset", {9'b0, qp_last_w}, {9'b0, 55'h12_3456_0000_0000});

    // Randomized traffic, with back-to-back requests holding stb
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: adr = 32'h3000_0000 | 32'($urandom_range(0, 3));
        1: adr = 32'h3100_0000 | 32'($urandom_range(0, 15) << 1) | 32'($urandom_range(0, 1));
        2: adr = 32'h3200_0000 | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 7) << 1)
                 | 32'($urandom_range(0, 1));
        3: adr = 32'h3400_0000 | 32'($urandom_range(0, 15));
        4: adr = 32'h3300_0000 | ($urandom & 32'h00FF_FFFF);
        default: adr = ($urandom_range(0, 1) ? 32'h3500_0000 : 32'h0000_0000) | ($urandom & 32'h00FF_FFFF);
      endcase
      op((adr == 32'h3000_0001) ? 1'b0 : 1'($urandom_range(0, 1)), adr, $urandom,
         (i == 199) ? 1'b0 : 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
